// File: rtl/input_decoder_pkg.sv
// input_decoder_pkg
// Shared definitions for the input decoder command sequencer.
//   - state_t  : sequencer states (IDLE, ARGS, DISCARD, VALID)
//   - hdr_t    : header word layout {opcode[3:0], nargs[3:0], imm[23:0]}
//   - OP_NOP   : opcode value that marks a NOP header
//   - HDR_*    : header field bit positions
package input_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARGS    = 2'd1,
    DISCARD = 2'd2,
    VALID   = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;

  localparam int HDR_OPCODE_MSB = 31;
  localparam int HDR_OPCODE_LSB = 28;
  localparam int HDR_NARGS_MSB  = 27;
  localparam int HDR_NARGS_LSB  = 24;
  localparam int HDR_IMM_MSB    = 23;
  localparam int HDR_IMM_LSB    = 0;

  // Field order matches the bit positions above, so a raw 32-bit FIFO word
  // can be cast straight to hdr_t.
  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  nargs;
    logic [23:0] imm;
  } hdr_t;

endpackage

// File: rtl/input_decoder_ctrl.sv
// input_decoder_ctrl
// Drains a 32-bit FWFT FIFO: pops a header, gathers its argument words and
// presents the assembled command downstream. NOPs and headers whose nargs
// exceed MAX_ARGS are consumed and dropped.
//
// Handshake: cmd_valid is high only in VALID, and every cmd_* output stays
// stable until the cycle in which cmd_ready=1 is seen with cmd_valid=1; that
// cycle is the transfer. flush has priority over cmd_ready, so a flushed
// command does not count as transferred.
//
// Ports:
//   clk, reset (async, active low)
//   fifo_empty, fifo_r_data (in)  FWFT FIFO head
//   fifo_read (out)               combinational pop strobe
//   flush (in)                    synchronous abort to IDLE
//   cmd_ready (in), cmd_valid (out), cmd_opcode/cmd_imm/cmd_nargs/cmd_args
//   err_illegal (out)             one-cycle pulse on oversized nargs
//   cmd_count (out)               commands accepted downstream (wraps)
//   dbg_state (out)               current sequencer state
module input_decoder_ctrl
  import input_decoder_pkg::*;
#(
  parameter int MAX_ARGS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    fifo_empty,
  input  logic [31:0]             fifo_r_data,
  output logic                    fifo_read,
  input  logic                    flush,
  input  logic                    cmd_ready,
  output logic                    cmd_valid,
  output logic [3:0]              cmd_opcode,
  output logic [23:0]             cmd_imm,
  output logic [3:0]              cmd_nargs,
  output logic [32*MAX_ARGS-1:0]  cmd_args,
  output logic                    err_illegal,
  output logic [CNT_W-1:0]        cmd_count,
  output state_t                  dbg_state
);

  localparam logic [3:0] MAX_ARGS_L = 4'(MAX_ARGS);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [3:0]               r_idx;
  logic [3:0]               r_remaining;
  logic [3:0]               r_opcode;
  logic [3:0]               r_nargs;
  logic [23:0]              r_imm;
  logic [32*MAX_ARGS-1:0]   r_args;
  logic                     r_err;
  logic [CNT_W-1:0]         r_count;

  hdr_t                     w_hdr;
  logic                     w_pop;
  logic                     w_load_hdr;
  logic                     w_store_arg;
  logic                     w_drop;
  logic                     w_accept;
  logic                     w_err;

  assign w_hdr = hdr_t'(fifo_r_data);

  // Next state and per-cycle strobes. flush overrides everything, so no pop
  // and no accept can happen in a flush cycle.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_load_hdr   = 1'b0;
    w_store_arg  = 1'b0;
    w_drop       = 1'b0;
    w_accept     = 1'b0;
    w_err        = 1'b0;
    if (flush) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!fifo_empty) begin
            w_pop      = 1'b1;
            w_load_hdr = 1'b1;
            if (w_hdr.nargs > MAX_ARGS_L) begin
              w_next_state = DISCARD;
              w_err        = 1'b1;
            end else if (w_hdr.opcode == OP_NOP) begin
              // NOP with arguments still has to skip those words
              w_next_state = (w_hdr.nargs == 4'd0) ? IDLE : DISCARD;
            end else if (w_hdr.nargs == 4'd0) begin
              w_next_state = VALID;
            end else begin
              w_next_state = ARGS;
            end
          end
        end
        ARGS: begin
          if (!fifo_empty) begin
            w_pop       = 1'b1;
            w_store_arg = 1'b1;
            if (r_idx == r_nargs - 4'd1) w_next_state = VALID;
          end
        end
        DISCARD: begin
          if (!fifo_empty) begin
            w_pop  = 1'b1;
            w_drop = 1'b1;
            if (r_remaining == 4'd1) w_next_state = IDLE;
          end
        end
        VALID: begin
          if (cmd_ready) begin
            w_accept     = 1'b1;
            w_next_state = IDLE;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx       <= '0;
      r_remaining <= '0;
      r_opcode    <= '0;
      r_nargs     <= '0;
      r_imm       <= '0;
      r_args      <= '0;
      r_err       <= 1'b0;
      r_count     <= '0;
    end else begin
      r_err <= w_err;
      if (w_load_hdr) begin
        r_opcode    <= w_hdr.opcode;
        r_nargs     <= w_hdr.nargs;
        r_imm       <= w_hdr.imm;
        r_args      <= '0;
        r_idx       <= '0;
        r_remaining <= w_hdr.nargs;
      end
      if (w_store_arg) begin
        for (int i = 0; i < MAX_ARGS; i++) begin
          if (r_idx == 4'(i)) r_args[32*i +: 32] <= fifo_r_data;
        end
        r_idx <= r_idx + 4'd1;
      end
      if (w_drop) r_remaining <= r_remaining - 4'd1;
      if (w_accept) r_count <= r_count + 1'b1;
    end
  end

  assign fifo_read   = w_pop;
  assign cmd_valid   = (r_state == VALID);
  assign cmd_opcode  = r_opcode;
  assign cmd_imm     = r_imm;
  assign cmd_nargs   = r_nargs;
  assign cmd_args    = r_args;
  assign err_illegal = r_err;
  assign cmd_count   = r_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_input_decoder_ctrl.sv
// tb_input_decoder_ctrl
// Directed bench for input_decoder_ctrl with a queue-based FWFT FIFO model.
module tb_input_decoder_ctrl;
  import input_decoder_pkg::*;

  logic          clk;
  logic          reset;
  logic          fifo_empty;
  logic [31:0]   fifo_r_data;
  logic          fifo_read;
  logic          flush;
  logic          cmd_ready;
  logic          cmd_valid;
  logic [3:0]    cmd_opcode;
  logic [23:0]   cmd_imm;
  logic [3:0]    cmd_nargs;
  logic [127:0]  cmd_args;
  logic          err_illegal;
  logic [15:0]   cmd_count;
  state_t        dbg_state;

  logic [31:0]   fifo_q[$];
  int            n_cmp;
  int            n_err;
  int            pop_cnt;
  int            valid_cnt;
  int            err_pulses;
  logic          rd_last;

  input_decoder_ctrl #(.MAX_ARGS(4), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_r_data (fifo_r_data),
    .fifo_read   (fifo_read),
    .flush       (flush),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_opcode  (cmd_opcode),
    .cmd_imm     (cmd_imm),
    .cmd_nargs   (cmd_nargs),
    .cmd_args    (cmd_args),
    .err_illegal (err_illegal),
    .cmd_count   (cmd_count),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty  = (fifo_q.size() == 0);
    fifo_r_data = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  // Entered just after a rising edge; samples outputs mid-cycle, lets one
  // edge pass, applies the pop to the FIFO model and refreshes its head.
  task automatic tick();
    #2;
    rd_last = fifo_read;
    if (cmd_valid)   valid_cnt++;
    if (err_illegal) err_pulses++;
    @(posedge clk);
    if (rd_last && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
    #1;
    drive_fifo();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; pop_cnt = 0; valid_cnt = 0; err_pulses = 0;
    rd_last = 1'b0;
    reset = 1'b0; flush = 1'b0; cmd_ready = 1'b0;
    drive_fifo();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 128'(cmd_valid), 128'd0);
    chk("rst_count", 128'(cmd_count), 128'd0);
    chk("rst_args",  cmd_args, 128'd0);
    chk("rst_err",   128'(err_illegal), 128'd0);
    chk("rst_state", 128'(dbg_state), 128'(IDLE));
    chk("rst_read",  128'(fifo_read), 128'd0);
    reset = 1'b1;

    // 1: header + two args, back-to-back pops
    fifo_q.push_back(32'h1200_00AB);
    fifo_q.push_back(32'h0000_0001);
    fifo_q.push_back(32'hFFFF_FFFF);
    drive_fifo();
    cmd_ready = 1'b1;
    pop_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_pop", 128'(rd_last), 128'd1);
    end
    chk("t1_valid",  128'(cmd_valid), 128'd1);
    chk("t1_opcode", 128'(cmd_opcode), 128'd1);
    chk("t1_nargs",  128'(cmd_nargs), 128'd2);
    chk("t1_imm",    128'(cmd_imm), 128'h0000AB);
    chk("t1_args",   cmd_args, {32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_0001});
    chk("t1_count0", 128'(cmd_count), 128'd0);
    tick();
    chk("t1_hs_read", 128'(rd_last), 128'd0);
    chk("t1_count",   128'(cmd_count), 128'd1);
    chk("t1_idle",    128'(cmd_valid), 128'd0);

    // 2: downstream backpressure holds the command
    cmd_ready = 1'b0;
    fifo_q.push_back(32'h3000_0007);
    fifo_q.push_back(32'h1000_0009);
    drive_fifo();
    tick();
    chk("t2_valid", 128'(cmd_valid), 128'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", 128'(cmd_valid), 128'd1);
      chk("t2_hold_read",  128'(rd_last), 128'd0);
      chk("t2_hold_op",    128'(cmd_opcode), 128'd3);
      chk("t2_hold_imm",   128'(cmd_imm), 128'h7);
    end
    cmd_ready = 1'b1;
    tick();
    chk("t2_count", 128'(cmd_count), 128'd2);
    chk("t2_state", 128'(dbg_state), 128'(IDLE));
    tick();
    chk("t2_next_pop", 128'(rd_last), 128'd1);
    chk("t2_next_imm", 128'(cmd_imm), 128'h9);
    chk("t2_next_vld", 128'(cmd_valid), 128'd1);
    tick();
    chk("t2_count2", 128'(cmd_count), 128'd3);

    // 3: oversized nargs is discarded, following command goes through
    cmd_ready = 1'b0;
    fifo_q.push_back(32'h2600_0000);
    for (int i = 1; i <= 6; i++) fifo_q.push_back(32'(i * 32'h11));
    fifo_q.push_back(32'h1000_0005);
    drive_fifo();
    pop_cnt = 0; valid_cnt = 0; err_pulses = 0;
    tick();
    chk("t3_err",     128'(err_illegal), 128'd1);
    chk("t3_discard", 128'(dbg_state), 128'(DISCARD));
    repeat (6) tick();
    chk("t3_idle",    128'(dbg_state), 128'(IDLE));
    chk("t3_err_lo",  128'(err_illegal), 128'd0);
    tick();
    chk("t3_pops",    128'(pop_cnt), 128'd8);
    chk("t3_novalid", 128'(valid_cnt), 128'd0);
    chk("t3_pulses",  128'(err_pulses), 128'd1);
    chk("t3_valid",   128'(cmd_valid), 128'd1);
    chk("t3_opcode",  128'(cmd_opcode), 128'd1);
    chk("t3_imm",     128'(cmd_imm), 128'h5);
    chk("t3_args",    cmd_args, 128'd0);
    cmd_ready = 1'b1;
    tick();
    chk("t3_count", 128'(cmd_count), 128'd4);

    // 4: NOPs are consumed silently
    fifo_q.push_back(32'h0000_0000);
    fifo_q.push_back(32'h0200_0000);
    fifo_q.push_back(32'hDEAD_BEEF);
    fifo_q.push_back(32'hCAFE_F00D);
    drive_fifo();
    pop_cnt = 0; valid_cnt = 0;
    repeat (6) tick();
    chk("t4_pops",    128'(pop_cnt), 128'd4);
    chk("t4_novalid", 128'(valid_cnt), 128'd0);
    chk("t4_count",   128'(cmd_count), 128'd4);
    chk("t4_state",   128'(dbg_state), 128'(IDLE));

    // 5: stall in ARGS, then reset mid-command
    fifo_q.push_back(32'h1300_0000);
    fifo_q.push_back(32'hAAAA_0001);
    drive_fifo();
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_stall_state", 128'(dbg_state), 128'(ARGS));
      chk("t5_stall_read",  128'(rd_last), 128'd0);
    end
    reset = 1'b0;
    #1;
    chk("t5_rst_valid", 128'(cmd_valid), 128'd0);
    chk("t5_rst_args",  cmd_args, 128'd0);
    chk("t5_rst_state", 128'(dbg_state), 128'(IDLE));
    chk("t5_rst_count", 128'(cmd_count), 128'd0);
    reset = 1'b1;
    fifo_q.push_back(32'h1000_0011);
    fifo_q.push_back(32'h2000_0022);
    drive_fifo();
    tick();
    chk("t5_hdr1_vld", 128'(cmd_valid), 128'd1);
    chk("t5_hdr1_imm", 128'(cmd_imm), 128'h11);
    tick();
    chk("t5_count1", 128'(cmd_count), 128'd1);
    tick();
    chk("t5_hdr2_op",  128'(cmd_opcode), 128'd2);
    chk("t5_hdr2_imm", 128'(cmd_imm), 128'h22);
    tick();
    chk("t5_count2", 128'(cmd_count), 128'd2);

    // 6: flush beats cmd_ready
    cmd_ready = 1'b0;
    fifo_q.push_back(32'h4000_0033);
    drive_fifo();
    tick();
    chk("t6_valid", 128'(cmd_valid), 128'd1);
    fifo_q.push_back(32'h5000_0044);
    drive_fifo();
    flush = 1'b1; cmd_ready = 1'b1;
    tick();
    chk("t6_flush_vld",   128'(cmd_valid), 128'd0);
    chk("t6_flush_count", 128'(cmd_count), 128'd2);
    #1;
    chk("t6_flush_noread", 128'(fifo_read), 128'd0);
    tick();
    chk("t6_flush_idle", 128'(dbg_state), 128'(IDLE));
    flush = 1'b0;
    tick();
    chk("t6_after_pop", 128'(rd_last), 128'd1);
    chk("t6_after_imm", 128'(cmd_imm), 128'h44);
    tick();
    chk("t6_after_count", 128'(cmd_count), 128'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_decoder_ctrl.md
Name: input_decoder_ctrl

Overview:
Command sequencer that drains the input decoder's 32-bit first-word-fall-through (FWFT) FIFO. It pops one header word, then gathers that header's argument words. It presents the assembled command to the downstream GPU pipeline with a valid/ready handshake. It also drops NOPs and malformed headers, so downstream only ever sees well-formed commands.

Parameters:
MAX_ARGS, 4, maximum argument words per command (1..15)
CNT_W, 16, width of the accepted-command counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
fifo_empty  input  1  FIFO empty flag
fifo_r_data  input  32  FIFO head word; valid whenever fifo_empty=0
fifo_read  output  1  pop strobe to FIFO (combinational)
flush  input  1  synchronous abort; return to IDLE
cmd_ready  input  1  downstream accepts command
cmd_valid  output  1  command held stable while asserted
cmd_opcode  output  4  header[31:28]
cmd_imm  output  24  header[23:0]
cmd_nargs  output  4  header[27:24]
cmd_args  output  32*MAX_ARGS  arg i at bits [32i+31:32i]; unused slots zero
err_illegal  output  1  one-cycle pulse: header nargs > MAX_ARGS
cmd_count  output  CNT_W  commands accepted downstream (wraps)

Behaviour:
- Header format: [31:28] opcode, [27:24] nargs, [23:0] imm. Opcode 4'h0 is NOP.
- Reset (async, reset=0) puts state in IDLE. It clears cmd_valid, err_illegal, cmd_opcode, cmd_imm, cmd_nargs, cmd_args, cmd_count and the arg index to 0. Reset mid-command discards any partial command; FIFO contents are untouched.
- fifo_read = !fifo_empty && (state is IDLE, ARGS or DISCARD) && !flush. It is never asserted in VALID.
- IDLE, fifo_empty=0: pop header, latch fields, clear cmd_args, clear idx to 0. Next state:
  - nargs > MAX_ARGS -> DISCARD, remaining = nargs; err_illegal pulses next cycle.
  - opcode = NOP and nargs = 0 -> IDLE (dropped).
  - NOP with nargs > 0 -> DISCARD.
  - nargs = 0 -> VALID.
  - otherwise -> ARGS.
- ARGS, fifo_empty=0: pop, cmd_args[idx] <= fifo_r_data, idx++. When idx = nargs-1 at the pop -> VALID. With fifo_empty=1, stall in ARGS; no timeout.
- DISCARD, fifo_empty=0: pop and drop, remaining--. When remaining = 1 at the pop -> IDLE.
- VALID: cmd_valid=1; all cmd_* outputs stable. On cmd_ready=1: cmd_count++, go to IDLE. The next header can be popped the following cycle.
- Latency: header pop at cycle t, N args on consecutive non-empty cycles, cmd_valid high at cycle t+N+1. Throughput is 1 word/cycle plus 1 handshake cycle per command.
- flush=1 in any state forces IDLE next cycle and clears cmd_valid. It pops nothing that cycle. It has priority over cmd_ready; cmd_count is not incremented.
- cmd_count wraps from 2^CNT_W-1 to 0.
- Simultaneous fifo_empty deassert and state transition: the decision uses current-cycle fifo_empty only.

Decomposition:
- Shared package input_decoder_pkg:
  - state enum {IDLE, ARGS, DISCARD, VALID}
  - opcode constant OP_NOP=4'h0
  - header field bit positions
  - header struct typedef {opcode[3:0], nargs[3:0], imm[23:0]}
- No sub-module. Pair it with the existing FIFO in a wrapper, input_decoder_top, owned separately.

Test Plan:
- Reset, then FIFO supplies 32'h1200_00AB, 32'h0000_0001, 32'hFFFF_FFFF with cmd_ready=1 -> three fifo_read pulses on consecutive cycles; cmd_valid one cycle later with opcode=1, nargs=2, imm=24'h0000AB, args[0]=1, args[1]=FFFF_FFFF, args[2..3]=0; cmd_count=1.
- Header 32'h3000_0007, cmd_ready=0 for 5 cycles -> cmd_valid held, fifo_read=0 throughout, outputs stable; raise cmd_ready -> cmd_count increments, next header popped following cycle.
- Header 32'h2600_0000 (nargs=6 > 4) followed by 6 words, then 32'h1000_0005 -> err_illegal single pulse, 7 pops, no cmd_valid until the opcode-1 command, imm=5.
- NOP 32'h0000_0000, then NOP 32'h0200_0000 + 2 words -> all consumed, cmd_valid never asserted, cmd_count unchanged.
- Header 32'h1300_0000, one arg, then fifo_empty=1 for 4 cycles -> stays ARGS, fifo_read=0; assert reset -> cmd_valid=0, cmd_args=0, state IDLE; the remaining FIFO words are then treated as headers.
- In VALID, assert flush and cmd_ready together -> cmd_valid drops next cycle, cmd_count unchanged.
